// File: rtl/seq_mult.sv
// seq_mult -- sequential shift-add multiplier with saturated fixed-point output.
//
// Takes two WIDTH-bit operands on a start pulse (signed or unsigned), walks the
// multiplier one bit per clock over magnitudes, then spends one more clock
// applying the sign and producing the Q-format view. Latency is WIDTH+1 clocks
// from the start edge to the done pulse, independent of the operand values.
//
// Ports:
//   i_clk          clock, all state changes on posedge
//   i_rst          synchronous active-high reset, highest priority
//   i_start        request, accepted only while idle
//   i_signed_mode  1 = two's-complement operands (sampled with i_start)
//   i_dataa        multiplicand (sampled with i_start)
//   i_datab        multiplier   (sampled with i_start)
//   o_busy         operation in progress
//   o_done         one-cycle pulse when o_result/o_result_q/o_sat update
//   o_result       full 2*WIDTH-bit product
//   o_result_q     product >>> FRAC, saturated to WIDTH bits
//   o_sat          o_result_q was clamped on the last operation
module seq_mult #(
  parameter int WIDTH = 18,
  parameter int FRAC  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_signed_mode,
  input  logic [WIDTH-1:0]   i_dataa,
  input  logic [WIDTH-1:0]   i_datab,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_result,
  output logic [WIDTH-1:0]   o_result_q,
  output logic               o_sat
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_idx;
  logic [PW-1:0]     r_acc;
  logic [WIDTH-1:0]  r_ma, r_mb;
  logic              r_neg, r_sgn;

  logic              w_accept, w_last;
  logic [WIDTH-1:0]  w_ma, w_mb;
  logic [PW-1:0]     w_p, w_qu, w_q;
  logic signed [PW-1:0] w_qs;
  logic              w_fit;
  logic [WIDTH-1:0]  w_qclamp;

  assign w_accept = (r_state == IDLE) && i_start;
  // idx == WIDTH is the extra finalize cycle after the last multiplier bit
  assign w_last   = (r_state == RUN) && (r_idx == IW'(WIDTH));

  // Two's-complement magnitude as an unsigned value: -2^(W-1) maps to 2^(W-1)
  assign w_ma = (i_signed_mode && i_dataa[WIDTH-1]) ? (~i_dataa + 1'b1) : i_dataa;
  assign w_mb = (i_signed_mode && i_datab[WIDTH-1]) ? (~i_datab + 1'b1) : i_datab;

  // Sign re-applied modulo 2^PW, then the truncating Q-format shift
  assign w_p  = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_qs = $signed(w_p) >>> FRAC;
  assign w_qu = w_p >> FRAC;
  assign w_q  = r_sgn ? PW'(w_qs) : w_qu;

  // Signed fits when all bits above the WIDTH-bit sign position match it;
  // unsigned fits when nothing is set above WIDTH bits.
  assign w_fit = r_sgn ? ((&w_q[PW-1:WIDTH-1]) | ~(|w_q[PW-1:WIDTH-1]))
                       : ~(|w_q[PW-1:WIDTH]);

  always_comb begin
    w_qclamp = w_q[WIDTH-1:0];
    if (!w_fit) begin
      if (!r_sgn)           w_qclamp = '1;
      else if (w_q[PW-1])   w_qclamp = {1'b1, {(WIDTH-1){1'b0}}};
      else                  w_qclamp = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = RUN;
      RUN:     if (w_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy = (r_state == RUN);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx      <= '0;
      r_acc      <= '0;
      r_ma       <= '0;
      r_mb       <= '0;
      r_neg      <= 1'b0;
      r_sgn      <= 1'b0;
      o_done     <= 1'b0;
      o_result   <= '0;
      o_result_q <= '0;
      o_sat      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (w_accept) begin
        r_ma  <= w_ma;
        r_mb  <= w_mb;
        r_neg <= i_signed_mode & (i_dataa[WIDTH-1] ^ i_datab[WIDTH-1]);
        r_sgn <= i_signed_mode;
        r_acc <= '0;
        r_idx <= '0;
      end else if (w_last) begin
        o_result   <= w_p;
        o_result_q <= w_qclamp;
        o_sat      <= ~w_fit;
        o_done     <= 1'b1;
      end else if (r_state == RUN) begin
        if (r_mb[r_idx]) r_acc <= r_acc + ({{WIDTH{1'b0}}, r_ma} << r_idx);
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult (WIDTH=18, FRAC=16).
module tb_seq_mult;
  localparam int W = 18;
  localparam int F = 16;

  logic            clk = 1'b0;
  logic            rst, start, sm;
  logic [W-1:0]    a, b;
  logic            busy, done, sat;
  logic [2*W-1:0]  result;
  logic [W-1:0]    result_q;

  int compared = 0;
  int mismatched = 0;
  int cnt;

  seq_mult #(.WIDTH(W), .FRAC(F)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed_mode(sm),
    .i_dataa(a), .i_datab(b), .o_busy(busy), .o_done(done),
    .o_result(result), .o_result_q(result_q), .o_sat(sat)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs and samples both sit 1 time unit after posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, count edges to done, check outputs and pulse width
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] da,
                        input logic [W-1:0] db, input logic [2*W-1:0] er,
                        input logic [W-1:0] eq, input logic es);
    sm = s; a = da; b = db; start = 1'b1;
    step();
    start = 1'b0; a = '0; b = '0;
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    cnt = 0;
    while (!done && cnt < 40) begin step(); cnt++; end
    chk({tag, ".latency"}, 64'(cnt), 64'd19);
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, ".result"}, 64'(result), 64'(er));
    chk({tag, ".result_q"}, 64'(result_q), 64'(eq));
    chk({tag, ".sat"}, 64'(sat), 64'(es));
    step();
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; sm = 1'b0; a = 18'h3FFFF; b = 18'h3FFFF;
    // Reset held two cycles with start high: nothing may begin
    step(); step();
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.result_q", 64'(result_q), 64'd0);
    chk("rst.sat", 64'(sat), 64'd0);
    rst = 1'b0; start = 1'b0;
    step();
    chk("rst.idle_after", 64'(busy), 64'd0);

    // Unsigned full-scale: (2^18-1)^2, Q view saturates
    run_op("u_max", 1'b0, 18'h3FFFF, 18'h3FFFF, 36'hFFFF80001, 18'h3FFFF, 1'b1);
    // Unsigned small
    run_op("u_small", 1'b0, 18'd5, 18'd7, 36'd35, 18'd0, 1'b0);
    // -2^17 * -2^17 = 2^34; Q = 2^18 clamps to +max
    run_op("s_minmin", 1'b1, 18'h20000, 18'h20000, 36'h400000000, 18'h1FFFF, 1'b1);
    // -1 * 3 = -3; Q = -1
    run_op("s_neg1x3", 1'b1, 18'h3FFFF, 18'd3, 36'hFFFFFFFFD, 18'h3FFFF, 1'b0);
    // Logistic-map step: 0.75 * 1.0
    run_op("s_logistic", 1'b1, 18'h0C000, 18'h10000, 36'h0C0000000, 18'h0C000, 1'b0);
    // -2^17 * (2^17-1): Q = -(2^18-2) clamps to -2^17
    run_op("s_negsat", 1'b1, 18'h20000, 18'h1FFFF, 36'hC00020000, 18'h20000, 1'b1);
    // -2^17 * 1: Q = -2, no clamp
    run_op("s_negnosat", 1'b1, 18'h20000, 18'd1, 36'hFFFFE0000, 18'h3FFFE, 1'b0);

    // Handshake: start at 0, ignored start at 5, back-to-back start in done cycle
    sm = 1'b0; a = 18'd5; b = 18'd7; start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 40) begin
      if (cnt == 4) begin sm = 1'b0; a = 18'd100; b = 18'd100; start = 1'b1; end
      else begin start = 1'b0; end
      step(); cnt++;
    end
    chk("hs.first_latency", 64'(cnt), 64'd19);
    chk("hs.first_result", 64'(result), 64'd35);
    sm = 1'b0; a = 18'h3FFFF; b = 18'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("hs.done_drops", 64'(done), 64'd0);
    chk("hs.third_busy", 64'(busy), 64'd1);
    cnt = 0;
    while (!done && cnt < 40) begin step(); cnt++; end
    chk("hs.third_latency", 64'(cnt), 64'd19);
    chk("hs.third_result", 64'(result), 64'h7FFFE);
    chk("hs.third_q", 64'(result_q), 64'h7);
    chk("hs.third_sat", 64'(sat), 64'd0);
    step();

    // Abort: reset during cycle 10 of an operation
    sm = 1'b1; a = 18'h3FFFF; b = 18'd3; start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin step(); if (done) cnt++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.result", 64'(result), 64'd0);
    chk("abort.result_q", 64'(result_q), 64'd0);
    chk("abort.sat", 64'(sat), 64'd0);
    for (int i = 0; i < 20; i++) begin step(); if (done) cnt++; end
    chk("abort.no_done", 64'(cnt), 64'd0);
    run_op("post_abort", 1'b1, 18'h0C000, 18'h10000, 36'h0C0000000, 18'h0C000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-add multiplier for the chaos-map datapath. It takes two WIDTH-bit operands through a start/done handshake and produces the full 2·WIDTH-bit product after a fixed WIDTH+1-cycle latency. Each operation can be signed or unsigned. The block also outputs a saturated fixed-point product (Q-format, FRAC fractional bits) that the map iteration logic feeds straight back as the next state.

## Interface
- WIDTH, 18: operand width, ≥2.
- FRAC, 16: fractional bits for result_q; 0 ≤ FRAC < WIDTH.
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- start  in  1  request; accepted only in IDLE.
- signed_mode  in  1  1 = two's-complement operands; sampled with start.
- dataa  in  WIDTH  multiplicand; sampled with start.
- datab  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result/result_q/sat are updated.
- result  out  2·WIDTH  full product; signed when signed_mode was 1.
- result_q  out  WIDTH  product >>> FRAC, saturated to WIDTH bits.
- sat  out  1  result_q was clamped on the last operation.

## Operation
- States: IDLE, RUN. Index counter ⌈log2(WIDTH+1)⌉ bits, accumulator 2·WIDTH bits, latched magnitude operands, sign flag.
- IDLE & start:
  - latch |dataa| and |datab|. In signed mode take the two's-complement magnitude as an unsigned WIDTH-bit value, so −2^(WIDTH−1) becomes 2^(WIDTH−1).
  - neg = signed_mode & (dataa[MSB] ^ datab[MSB]).
  - clear accumulator and index; go to RUN.
- RUN, one multiplier bit per cycle: if mb[index] then acc += ma << index; index++.
- After the bit WIDTH−1 step:
  - p = neg ? −acc : acc, taken modulo 2^(2·WIDTH).
  - register result ← p.
  - q = p >>> FRAC. Arithmetic shift in signed mode, logical in unsigned mode.
  - result_q ← q clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1] in signed mode, or [0, 2^WIDTH−1] in unsigned mode. sat ← 1 if clamped, else 0. The shift truncates; there is no rounding.
  - done ← 1 for that cycle; go to IDLE.
- start while busy: ignored. Operand inputs are don't-care outside the start cycle.
- result, result_q and sat hold their values until the next completion or reset.
- Magnitude arithmetic never overflows: max |product| = 2^(2·WIDTH−2) in signed mode, (2^WIDTH−1)² in unsigned mode.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, result_q 0, sat 0, internal acc/index 0.
- RST has priority over everything. RST mid-operation aborts it; done does not pulse; outputs go to their reset values on the next edge.
- Start accepted at edge k:
  - busy = 1 from after edge k through edge k+WIDTH.
  - done = 1 and outputs valid after edge k+WIDTH+1; busy = 0 in that same cycle.
  - Latency is WIDTH+1 cycles, independent of the data.
- Back-to-back operation: start asserted during the done cycle is accepted, since the state is IDLE. Throughput is one result per WIDTH+1 cycles.
- start and RST in the same cycle: reset wins and start is dropped.

## Test plan
- Reset: hold RST 2 cycles with start=1 → busy=0, done=0, result=0, sat=0; no operation begins.
- Unsigned, WIDTH=18: dataa=datab=0x3FFFF → done exactly 19 cycles after the start edge; result=0xFFFF80001. With FRAC=16, result_q=0x3FFFF and sat=1.
- Signed, WIDTH=18, FRAC=16:
  - 0x20000 × 0x20000 (−2^17 · −2^17) → result=0x400000000.
  - −1 × 3 → result=0xFFFFFFFFD, result_q=0x3FFFF (−1), sat=0.
- Logistic-map step, Q2.16, signed: 0x0C000 (0.75) × 0x10000 (1.0) → result=0x0C0000000, result_q=0x0C000, sat=0.
- Handshake: pulse start at cycle 0, then again at cycles 5 and 19 (the done cycle) with different operands → the second request is ignored; the third is accepted and its done arrives at cycle 38.
- Abort: RST asserted at cycle 10 of an operation → no done pulse, outputs cleared. A new start after reset produces a correct product.
